fir_out_collector: RTL

- Downstream stage of the FIR filter.
- Captures each 9-bit filter result into a small FIFO and presents the results to a consumer over a valid/ready interface.
- Drives the FIR's halt input as backpressure when the FIFO nears full.
- Reports per-frame statistics (sample count, peak value) when the FIR signals done.

---
 rtl/fir_coll_pkg.sv | 18 +
 rtl/fir_coll_fifo.sv | 64 ++++++
 rtl/fir_out_collector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fir_coll_pkg.sv
// Shared types and helpers for the FIR output collector.
// The frame statistics logic in the top is built only when FIR_COLL_STATS_EN is defined.
package fir_coll_pkg;

    localparam int DATA_W = 9;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_REPORT
    } frame_state_t;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fir_coll_fifo.sv
// Show-ahead FIFO of DEPTH entries (power of two) with registered occupancy.
// Callers must only push when not full (or popping) and only pop when not empty.
module fir_coll_fifo
    import fir_coll_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_occNext
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_occ;
    logic [AW:0]       w_occNext;

    assign o_empty   = (r_occ == '0);
    assign o_full    = (r_occ == FULL_OCC);
    assign o_data    = o_empty ? '0 : r_mem[r_rdPtr];
    assign o_occNext = w_occNext;

    always_comb begin
        w_occNext = r_occ;
        if (i_push && !i_pop) begin
            w_occNext = r_occ + 1'b1;
        end else if (!i_push && i_pop) begin
            w_occNext = r_occ - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            r_occ <= w_occNext;
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/fir_out_collector.sv
// Collects FIR results into a FIFO with halt backpressure and sticky overflow.
// Per-frame statistics (frame_cnt/frame_max/stat_vld) exist only with FIR_COLL_STATS_EN defined.
module fir_out_collector
    import fir_coll_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HALT_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    input  logic              in_done,
    output logic              halt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              ovf,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [DATA_W-1:0] frame_max,
    output logic              stat_vld
);
    localparam int AW = $clog2(DEPTH);

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_occNext;
    logic        r_halt;
    logic        r_ovf;

    assign w_pop   = ~w_empty & out_rdy;
    assign w_push  = in_vld & (~w_full | w_pop);
    assign out_vld = ~w_empty;
    assign halt    = r_halt;
    assign ovf     = r_ovf;

    fir_coll_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (in_data),
        .o_data   (out_data),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .o_occNext(w_occNext)
    );

    // Halt looks at next-state occupancy so it rises in step with the push that crosses the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_halt <= (int'(w_occNext) >= DEPTH - HALT_MARGIN);
            if (in_vld && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef FIR_COLL_STATS_EN
    frame_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_max;
    logic [CNT_W-1:0]  r_frameCnt;
    logic [DATA_W-1:0] r_frameMax;
    logic              r_statVld;
    logic [CNT_W-1:0]  w_cntAcc;
    logic [DATA_W-1:0] w_maxAcc;

    // Accumulators are zero outside a frame, so one update rule also starts a new frame.
    always_comb begin
        w_cntAcc = r_cnt;
        w_maxAcc = r_max;
        if (in_vld) begin
            w_cntAcc = satInc(r_cnt);
            if (in_data > r_max) begin
                w_maxAcc = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_max      <= '0;
            r_frameCnt <= '0;
            r_frameMax <= '0;
            r_statVld  <= 1'b0;
        end else begin
            r_statVld <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ACTIVE: begin
                    if (in_done) begin
                        r_frameCnt <= w_cntAcc;
                        r_frameMax <= w_maxAcc;
                        r_statVld  <= 1'b1;
                        r_cnt      <= '0;
                        r_max      <= '0;
                        r_state    <= ST_REPORT;
                    end else begin
                        r_cnt <= w_cntAcc;
                        r_max <= w_maxAcc;
                        if (in_vld) begin
                            r_state <= ST_ACTIVE;
                        end
                    end
                end
                ST_REPORT: begin
                    r_cnt   <= w_cntAcc;
                    r_max   <= w_maxAcc;
                    r_state <= in_vld ? ST_ACTIVE : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign frame_cnt = r_frameCnt;
    assign frame_max = r_frameMax;
    assign stat_vld  = r_statVld;
`else
    logic w_unusedDone;

    assign w_unusedDone = in_done;
    assign frame_cnt    = '0;
    assign frame_max    = '0;
    assign stat_vld     = 1'b0;
`endif

endmodule
